// File: rtl/alu_pkg.sv
// Shared types for the ALU request controller: ALU op encodings, request
// command codes and the controller FSM states.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_AND = 3'b000;
  localparam alu_op_t ALU_OR  = 3'b001;
  localparam alu_op_t ALU_ADD = 3'b010;
  localparam alu_op_t ALU_SUB = 3'b110;
  localparam alu_op_t ALU_SLL = 3'b100;
  localparam alu_op_t ALU_SRL = 3'b101;

  typedef logic [2:0] req_cmd_t;

  localparam req_cmd_t CMD_AND = 3'd0;
  localparam req_cmd_t CMD_OR  = 3'd1;
  localparam req_cmd_t CMD_ADD = 3'd2;
  localparam req_cmd_t CMD_SUB = 3'd3;
  localparam req_cmd_t CMD_SLL = 3'd4;
  localparam req_cmd_t CMD_SRL = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/alu_cmd_decoder.sv
// Combinational translation of a high-level request command to the ALU op
// select; codes 6 and 7 are flagged illegal and never reach the ALU.
module alu_cmd_decoder
  import alu_pkg::*;
(
  input  req_cmd_t cmd_i,
  output alu_op_t  op_o,
  output logic     illegal_o
);

  always_comb begin
    op_o      = ALU_AND;
    illegal_o = 1'b0;
    case (cmd_i)
      CMD_AND: op_o = ALU_AND;
      CMD_OR:  op_o = ALU_OR;
      CMD_ADD: op_o = ALU_ADD;
      CMD_SUB: op_o = ALU_SUB;
      CMD_SLL: op_o = ALU_SLL;
      CMD_SRL: op_o = ALU_SRL;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_request_controller.sv
// Initiator side of the ALU interface: issues one request at a time, waits out
// the ALU latency and returns the flags. Optional macro: ALU_ZERO_LOCAL_EN.
module alu_request_controller
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RES_LAT  = 2,
  parameter int ZERO_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_cmd,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic              rsp_error
);

  // Sized for the longer zero-flag wait so both capture points fit.
  localparam int CNT_W = $clog2(ZERO_LAT + 2);
  localparam logic [CNT_W-1:0] RES_CAP  = CNT_W'(RES_LAT + 1);
`ifndef ALU_ZERO_LOCAL_EN
  localparam logic [CNT_W-1:0] ZERO_CAP = CNT_W'(ZERO_LAT + 1);
`endif

  ctrl_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  alu_op_t           op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  alu_op_t dec_op;
  logic    dec_illegal;

  alu_cmd_decoder u_dec (
    .cmd_i     (req_cmd),
    .op_o      (dec_op),
    .illegal_o (dec_illegal)
  );

`ifdef ALU_ZERO_LOCAL_EN
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= ALU_AND;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (dec_illegal) begin
            // Illegal commands never disturb the ALU operands.
            res_d   = '0;
            zero_d  = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            op_d    = dec_op;
            a_d     = req_a;
            b_d     = req_b;
            cnt_d   = CNT_W'(1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RES_CAP) begin
          res_d = alu_result;
          ovf_d = alu_overflow;
`ifdef ALU_ZERO_LOCAL_EN
          zero_d  = (alu_result == '0);
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RESP;
`endif
        end
`ifndef ALU_ZERO_LOCAL_EN
        if (cnt_q == ZERO_CAP) begin
          zero_d  = alu_zero;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign alu_op       = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign rsp_result   = res_q;
  assign rsp_zero     = zero_q;
  assign rsp_overflow = ovf_q;
  assign rsp_error    = err_q;

endmodule

// File: tb/tb_alu_request_controller.sv
// Directed bench for alu_request_controller with a registered ALU model
// (result after 2 edges, zero flag after 3 edges).
module tb_alu_request_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [31:0] req_a, req_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result;
  logic        alu_zero, alu_overflow;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_overflow, rsp_error;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ALU_ZERO_LOCAL_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 4;
`endif

  alu_request_controller #(.DATA_W(32), .RES_LAT(2), .ZERO_LAT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_error    (rsp_error)
  );

  always #5 clk = ~clk;

  // ALU model: bit 32 is carry/borrow/shifted-out bit; 011/111 hold stale output.
  logic [32:0] s1, s2;
  logic        za, zb;
  always @(posedge clk) begin
    case (alu_op)
      3'b000:  s1 <= {1'b0, alu_a & alu_b};
      3'b001:  s1 <= {1'b0, alu_a | alu_b};
      3'b010:  s1 <= {1'b0, alu_a} + {1'b0, alu_b};
      3'b110:  s1 <= {1'b0, alu_a} - {1'b0, alu_b};
      3'b100:  s1 <= {alu_a, 1'b0};
      3'b101:  s1 <= {2'b00, alu_a[31:1]};
      default: s1 <= s1;
    endcase
    s2 <= s1;
    za <= (s1[31:0] == 32'd0);
    zb <= za;
  end
  assign alu_result   = s2[31:0];
  assign alu_overflow = s2[32];
  assign alu_zero     = zb;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        err;
    logic [2:0]  op;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, then waits (bounded) for rsp_valid.
  task automatic run_txn(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
    req_cmd   = 3'(($urandom_range(0, 7)));
    req_a     = $urandom;
    req_b     = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int          lat;
    logic [2:0]  last_op;
    logic [31:0] last_a, last_b;
    logic        seen;

    //            cmd   a             b             res           z     o     e     op
    vecs[0]  = '{3'd2, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1'b0, 3'b010};
    vecs[1]  = '{3'd3, 32'd7,        32'd7,        32'd0,        1'b1, 1'b0, 1'b0, 3'b110};
    vecs[2]  = '{3'd3, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 3'b110};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1, 1'b0, 3'b010};
    vecs[4]  = '{3'd4, 32'h80000000, 32'd0,        32'd0,        1'b1, 1'b1, 1'b0, 3'b100};
    vecs[5]  = '{3'd0, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[6]  = '{3'd1, 32'h00001200, 32'h00340000, 32'h00341200, 1'b0, 1'b0, 1'b0, 3'b001};
    vecs[7]  = '{3'd5, 32'h00000003, 32'h0000AAAA, 32'h00000001, 1'b0, 1'b0, 1'b0, 3'b101};
    vecs[8]  = '{3'd6, 32'h12345678, 32'h9ABCDEF0, 32'd0,        1'b0, 1'b0, 1'b1, 3'b000};
    vecs[9]  = '{3'd7, 32'h55555555, 32'hAAAAAAAA, 32'd0,        1'b0, 1'b0, 1'b1, 3'b000};
    vecs[10] = '{3'd0, 32'd0,        32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 3'b000};

    rst = 1'b1; req_valid = 1'b0; req_cmd = 3'd0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_op",    64'(alu_op),    64'd0);
    chk("rst_alu_a",     64'(alu_a),     64'd0);
    chk("rst_alu_b",     64'(alu_b),     64'd0);
    chk("rst_rsp_flags", 64'({rsp_result, rsp_zero, rsp_overflow, rsp_error}), 64'd0);

    last_op = 3'b000; last_a = '0; last_b = '0;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'd1);
      run_txn(vecs[i].cmd, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), vecs[i].err ? 64'd0 : 64'(EXP_LAT));
      chk($sformatf("v%0d_result", i), 64'(rsp_result),   64'(vecs[i].res));
      chk($sformatf("v%0d_zero", i),   64'(rsp_zero),     64'(vecs[i].zero));
      chk($sformatf("v%0d_ovf", i),    64'(rsp_overflow), 64'(vecs[i].ovf));
      chk($sformatf("v%0d_err", i),    64'(rsp_error),    64'(vecs[i].err));
      if (!vecs[i].err) begin
        last_op = vecs[i].op; last_a = vecs[i].a; last_b = vecs[i].b;
      end
      chk($sformatf("v%0d_alu_op", i), 64'(alu_op), 64'(last_op));
      chk($sformatf("v%0d_alu_a", i),  64'(alu_a),  64'(last_a));
      chk($sformatf("v%0d_alu_b", i),  64'(alu_b),  64'(last_b));
      tick();
      chk($sformatf("v%0d_post_valid", i), 64'(rsp_valid), 64'd0);
      chk($sformatf("v%0d_post_ready", i), 64'(req_ready), 64'd1);
    end

    // Backpressure: response held, competing request ignored, no bypass on handshake.
    rsp_ready = 1'b0;
    run_txn(3'd2, 32'd10, 32'd20, lat);
    chk("bp_latency", 64'(lat), 64'(EXP_LAT));
    req_valid = 1'b1; req_cmd = 3'd3; req_a = 32'd1; req_b = 32'd2;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp%0d_valid", k),  64'(rsp_valid),  64'd1);
      chk($sformatf("bp%0d_ready", k),  64'(req_ready),  64'd0);
      chk($sformatf("bp%0d_result", k), 64'(rsp_result), 64'd30);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_hs_valid", 64'(rsp_valid), 64'd0);
    chk("bp_hs_ready", 64'(req_ready), 64'd1);
    chk("bp_no_bypass_a",  64'(alu_a),  64'd10);
    chk("bp_no_bypass_op", 64'(alu_op), 64'b010);
    req_valid = 1'b0;
    tick();

    // Reset two cycles into an ADD abandons it.
    req_valid = 1'b1; req_cmd = 3'd2; req_a = 32'd100; req_b = 32'd1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_alu",       64'({alu_op, alu_a, alu_b}), 64'd0);
    chk("mid_rst_rsp",       64'({rsp_result, rsp_zero, rsp_overflow, rsp_error}), 64'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_rst_no_rsp", 64'(seen), 64'd0);
    run_txn(3'd2, 32'd2, 32'd3, lat);
    chk("after_rst_latency", 64'(lat), 64'(EXP_LAT));
    chk("after_rst_result",  64'(rsp_result), 64'd5);
    chk("after_rst_flags",   64'({rsp_zero, rsp_overflow, rsp_error}), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
